// File: rtl/amstrad_crtc_pkg.sv
// Shared definitions for the CRTC: register indices, CPC reset defaults and the
// vertical FSM state type.
package amstrad_crtc_pkg;

  localparam logic [4:0] R_HTOTAL    = 5'd0;
  localparam logic [4:0] R_HDISP     = 5'd1;
  localparam logic [4:0] R_HSYNCPOS  = 5'd2;
  localparam logic [4:0] R_SYNCWIDTH = 5'd3;
  localparam logic [4:0] R_VTOTAL    = 5'd4;
  localparam logic [4:0] R_VADJUST   = 5'd5;
  localparam logic [4:0] R_VDISP     = 5'd6;
  localparam logic [4:0] R_VSYNCPOS  = 5'd7;
  localparam logic [4:0] R_MAXRASTER = 5'd9;
  localparam logic [4:0] R_STARTH    = 5'd12;
  localparam logic [4:0] R_STARTL    = 5'd13;

  typedef struct packed {
    logic [7:0] htotal;
    logic [7:0] hdisp;
    logic [7:0] hsyncpos;
    logic [7:0] syncw;
    logic [6:0] vtotal;
    logic [4:0] vadjust;
    logic [6:0] vdisp;
    logic [6:0] vsyncpos;
    logic [4:0] maxraster;
    logic [5:0] start_h;
    logic [7:0] start_l;
  } crtc_regs_t;

  localparam crtc_regs_t REG_DEFAULTS = '{
    htotal:    8'd63,
    hdisp:     8'd40,
    hsyncpos:  8'd46,
    syncw:     8'h8E,
    vtotal:    7'd38,
    vadjust:   5'd0,
    vdisp:     7'd25,
    vsyncpos:  7'd30,
    maxraster: 5'd7,
    start_h:   6'h30,
    start_l:   8'h00
  };

  typedef enum logic {ACTIVE = 1'b0, ADJUST = 1'b1} vstate_e;

endpackage

// File: rtl/amstrad_crtc_regs.sv
// CPU side of the CRTC: address latch, register file and the R12/R13 read path.
module amstrad_crtc_regs
  import amstrad_crtc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       rs_i,
  input  logic       we_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o,
  output crtc_regs_t regs_o
);

  logic [4:0] addr_q;
  crtc_regs_t regs_q;
  logic [7:0] q_q, q_d;
  logic       wr;

  assign wr     = cs_i & we_i;
  assign q_o    = q_q;
  assign regs_o = regs_q;

  always_comb begin
    q_d = '0;
    if (rs_i) begin
      case (addr_q)
        R_STARTH: q_d = {2'b00, regs_q.start_h};
        R_STARTL: q_d = regs_q.start_l;
        default:  q_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      regs_q <= REG_DEFAULTS;
      q_q    <= '0;
    end else begin
      q_q <= q_d;
      if (wr && !rs_i) addr_q <= d_i[4:0];
      // R8 and unlisted indices fall through to default and are dropped
      if (wr && rs_i) begin
        case (addr_q)
          R_HTOTAL:    regs_q.htotal    <= d_i;
          R_HDISP:     regs_q.hdisp     <= d_i;
          R_HSYNCPOS:  regs_q.hsyncpos  <= d_i;
          R_SYNCWIDTH: regs_q.syncw     <= d_i;
          R_VTOTAL:    regs_q.vtotal    <= d_i[6:0];
          R_VADJUST:   regs_q.vadjust   <= d_i[4:0];
          R_VDISP:     regs_q.vdisp     <= d_i[6:0];
          R_VSYNCPOS:  regs_q.vsyncpos  <= d_i[6:0];
          R_MAXRASTER: regs_q.maxraster <= d_i[4:0];
          R_STARTH:    regs_q.start_h   <= d_i[5:0];
          R_STARTL:    regs_q.start_l   <= d_i;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: rtl/amstrad_crtc.sv
// 6845-class CRTC: character/line/row counters, ACTIVE/ADJUST vertical FSM,
// sync generation and video memory addressing, all advanced on CE.
module amstrad_crtc
  import amstrad_crtc_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        CS,
  input  logic        RS,
  input  logic        WE,
  input  logic [7:0]  D,
  output logic [7:0]  Q,
  output logic [13:0] MA,
  output logic [4:0]  RA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE
);

  crtc_regs_t regs;

  amstrad_crtc_regs u_regs (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .cs_i   (CS),
    .rs_i   (RS),
    .we_i   (WE),
    .d_i    (D),
    .q_o    (Q),
    .regs_o (regs)
  );

  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  vlc_q, vlc_d;
  logic [6:0]  vcc_q, vcc_d;
  vstate_e     state_q, state_d;
  logic [4:0]  adj_cnt_q, adj_cnt_d;
  logic        hdisp_q, hdisp_d;
  logic        hs_q, hs_d;
  logic [3:0]  hs_cnt_q, hs_cnt_d;
  logic        vs_q, vs_d;
  logic [3:0]  vs_cnt_q, vs_cnt_d;
  logic        vs_done_q, vs_done_d;
  logic [13:0] ma_row_q, ma_row_d;
  logic [13:0] ma_next_q, ma_next_d;
  logic [13:0] ma_q, ma_d;
  logic        de_q, de_d;
  logic        line_end, row_end, frame_start;

  assign line_end = (hcc_q == regs.htotal);
  assign row_end  = (vlc_q == regs.maxraster);

  assign MA    = ma_q;
  assign RA    = vlc_q;
  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
  assign DE    = de_q;

  always_comb begin
    hcc_d       = hcc_q;
    vlc_d       = vlc_q;
    vcc_d       = vcc_q;
    state_d     = state_q;
    adj_cnt_d   = adj_cnt_q;
    hdisp_d     = hdisp_q;
    hs_d        = hs_q;
    hs_cnt_d    = hs_cnt_q;
    vs_d        = vs_q;
    vs_cnt_d    = vs_cnt_q;
    vs_done_d   = vs_done_q;
    ma_row_d    = ma_row_q;
    ma_next_d   = ma_next_q;
    ma_d        = ma_q;
    de_d        = de_q;
    frame_start = 1'b0;

    if (CE) begin
      hcc_d = line_end ? 8'd0 : hcc_q + 8'd1;
      if (hcc_q == regs.hdisp && row_end)
        ma_next_d = ma_row_q + {6'd0, regs.hdisp};

      if (line_end) begin
        case (state_q)
          ACTIVE: begin
            if (row_end) begin
              vlc_d = 5'd0;
              if (vcc_q == regs.vtotal) begin
                if (regs.vadjust == 5'd0) begin
                  frame_start = 1'b1;
                end else begin
                  state_d   = ADJUST;
                  adj_cnt_d = regs.vadjust - 5'd1;
                end
              end else begin
                vcc_d    = vcc_q + 7'd1;
                ma_row_d = ma_next_q;
              end
            end else begin
              vlc_d = vlc_q + 5'd1;
            end
          end
          ADJUST: begin
            if (adj_cnt_q == 5'd0) begin
              frame_start = 1'b1;
            end else begin
              adj_cnt_d = adj_cnt_q - 5'd1;
              vlc_d     = vlc_q + 5'd1;
            end
          end
          default: state_d = ACTIVE;
        endcase

        if (frame_start) begin
          state_d   = ACTIVE;
          vcc_d     = 7'd0;
          vlc_d     = 5'd0;
          ma_row_d  = {regs.start_h, regs.start_l};
          vs_done_d = 1'b0;
        end

        // a running VSYNC keeps counting across a frame restart
        if (vcc_d == regs.vsyncpos && vlc_d == 5'd0 && !vs_done_d) begin
          vs_d      = 1'b1;
          vs_cnt_d  = regs.syncw[7:4] - 4'd1;
          vs_done_d = 1'b1;
        end else if (vs_q) begin
          if (vs_cnt_q == 4'd0) vs_d = 1'b0;
          else                  vs_cnt_d = vs_cnt_q - 4'd1;
        end
      end

      if (hcc_d == regs.hdisp)  hdisp_d = 1'b0;
      else if (hcc_d == 8'd0)   hdisp_d = 1'b1;

      if (hcc_d == regs.hsyncpos && regs.syncw[3:0] != 4'd0) begin
        hs_d     = 1'b1;
        hs_cnt_d = regs.syncw[3:0] - 4'd1;
      end else if (hs_q) begin
        if (hs_cnt_q == 4'd0) hs_d = 1'b0;
        else                  hs_cnt_d = hs_cnt_q - 4'd1;
      end

      de_d = hdisp_d && (vcc_d < regs.vdisp) && (state_d == ACTIVE);
      ma_d = ma_row_d + {6'd0, hcc_d};
    end
  end

  // hcc=0 is a display-start position, so the display flag comes out of reset set
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcc_q     <= '0;
      vlc_q     <= '0;
      vcc_q     <= '0;
      state_q   <= ACTIVE;
      adj_cnt_q <= '0;
      hdisp_q   <= 1'b1;
      hs_q      <= 1'b0;
      hs_cnt_q  <= '0;
      vs_q      <= 1'b0;
      vs_cnt_q  <= '0;
      vs_done_q <= 1'b0;
      ma_row_q  <= {REG_DEFAULTS.start_h, REG_DEFAULTS.start_l};
      ma_next_q <= '0;
      ma_q      <= '0;
      de_q      <= 1'b0;
    end else begin
      hcc_q     <= hcc_d;
      vlc_q     <= vlc_d;
      vcc_q     <= vcc_d;
      state_q   <= state_d;
      adj_cnt_q <= adj_cnt_d;
      hdisp_q   <= hdisp_d;
      hs_q      <= hs_d;
      hs_cnt_q  <= hs_cnt_d;
      vs_q      <= vs_d;
      vs_cnt_q  <= vs_cnt_d;
      vs_done_q <= vs_done_d;
      ma_row_q  <= ma_row_d;
      ma_next_q <= ma_next_d;
      ma_q      <= ma_d;
      de_q      <= de_d;
    end
  end

endmodule

// File: tb/tb_amstrad_crtc.sv
// Directed bench for amstrad_crtc: register table plus frame-level timing sequences.
module tb_amstrad_crtc;

  logic        CLK = 1'b0;
  logic        RESET, CE, CS, RS, WE;
  logic [7:0]  D, Q;
  logic [13:0] MA;
  logic [4:0]  RA;
  logic        HSYNC, VSYNC, DE;

  int n_vec = 0;
  int n_err = 0;

  amstrad_crtc dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .CS(CS), .RS(RS), .WE(WE), .D(D),
    .Q(Q), .MA(MA), .RA(RA), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] idx;
    logic       do_wr;
    logic [7:0] wdata;
    logic [7:0] q_exp;
  } reg_vec_t;

  reg_vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic ce_step();
    CE = 1'b1;
    tick();
    CE = 1'b0;
  endtask

  task automatic wr(input logic rs, input logic [7:0] data);
    CS = 1'b1; WE = 1'b1; RS = rs; D = data;
    tick();
    CS = 1'b0; WE = 1'b0; RS = 1'b0;
  endtask

  task automatic wreg(input logic [4:0] idx, input logic [7:0] data);
    wr(1'b0, {3'b000, idx});
    wr(1'b1, data);
  endtask

  task automatic rd(output logic [7:0] q);
    CS = 1'b1; WE = 1'b0; RS = 1'b1;
    tick();
    q = Q;
    CS = 1'b0; RS = 1'b0;
  endtask

  // steps CE until HSYNC equals lvl; returns steps taken, or -1 if the budget ran out
  task automatic steps_until_hs(input logic lvl, output int cnt);
    cnt = 0;
    while (HSYNC !== lvl && cnt < 200) begin ce_step(); cnt++; end
    if (HSYNC !== lvl) cnt = -1;
  endtask

  initial begin
    logic [7:0] qv;
    int e_hs, e_de, e_vs, e_ra, e_ma, cnt, mx;

    tbl[0] = '{5'd12, 1'b0, 8'h00, 8'h30};
    tbl[1] = '{5'd13, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{5'd12, 1'b1, 8'hFF, 8'h3F};
    tbl[3] = '{5'd13, 1'b1, 8'hA5, 8'hA5};
    tbl[4] = '{5'd0,  1'b0, 8'h00, 8'h00};
    tbl[5] = '{5'd10, 1'b1, 8'h55, 8'h00};
    tbl[6] = '{5'd12, 1'b1, 8'h0C, 8'h0C};
    tbl[7] = '{5'd28, 1'b1, 8'h11, 8'h00};
    tbl[8] = '{5'd12, 1'b0, 8'h00, 8'h0C};
    tbl[9] = '{5'd13, 1'b1, 8'h00, 8'h00};

    RESET = 1'b1; CE = 1'b0; CS = 1'b0; RS = 1'b0; WE = 1'b0; D = '0;
    repeat (3) tick();
    chk("reset_ma", int'(MA), 0);
    chk("reset_ra", int'(RA), 0);
    chk("reset_sync", int'({HSYNC, VSYNC, DE}), 0);
    chk("reset_q", int'(Q), 0);
    #2 RESET = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      wr(1'b0, {3'b000, tbl[i].idx});
      if (tbl[i].do_wr) wr(1'b1, tbl[i].wdata);
      rd(qv);
      chk($sformatf("reg_tbl[%0d]", i), int'(qv), int'(tbl[i].q_exp));
    end

    // frame 1: CPC defaults (R12/R13 only matter at the next reload)
    e_hs = 0; e_de = 0; e_vs = 0; e_ra = 0;
    for (int n = 1; n < 19968; n++) begin
      int h, ln;
      ce_step();
      h = n % 64; ln = n / 64;
      if (HSYNC !== (h >= 46 && h < 60)) e_hs++;
      if (DE !== (h < 40 && ln < 200)) e_de++;
      if (VSYNC !== (ln >= 240 && ln < 248)) e_vs++;
      if (int'(RA) != ln % 8) e_ra++;
    end
    chk("f1_hsync_errs", e_hs, 0);
    chk("f1_de_errs", e_de, 0);
    chk("f1_vsync_errs", e_vs, 0);
    chk("f1_ra_errs", e_ra, 0);
    ce_step();
    chk("f2_first_ma", int'(MA), 16'h0C00);
    chk("f2_first_ra", int'(RA), 0);

    wreg(5'd5, 8'd2);
    wreg(5'd3, 8'h00);
    repeat (5) tick();
    chk("ce_gate_ma", int'(MA), 16'h0C00);

    // frame 2: two adjust lines, no HSYNC, 16-line VSYNC, start address 0x0C00
    e_hs = 0; e_de = 0; e_vs = 0; e_ra = 0; e_ma = 0;
    for (int n = 1; n < 20096; n++) begin
      int h, ln;
      ce_step();
      h = n % 64; ln = n / 64;
      if (HSYNC !== 1'b0) e_hs++;
      if (DE !== (h < 40 && ln < 200)) e_de++;
      if (VSYNC !== (ln >= 240 && ln < 256)) e_vs++;
      if (int'(RA) != ((ln < 312) ? ln % 8 : ln - 312)) e_ra++;
      if (ln < 312 && int'(MA) != ((16'h0C00 + (ln / 8) * 40 + h) & 16'h3FFF)) e_ma++;
      if (n == 512) chk("f2_row1_ma", int'(MA), 16'h0C28);
    end
    chk("f2_hsync_errs", e_hs, 0);
    chk("f2_de_errs", e_de, 0);
    chk("f2_vsync_errs", e_vs, 0);
    chk("f2_ra_errs", e_ra, 0);
    chk("f2_ma_errs", e_ma, 0);
    ce_step();
    chk("f3_first_ma", int'(MA), 16'h0C00);
    chk("f3_first_ra", int'(RA), 0);

    // one-line frames starting near the top of the address space
    wreg(5'd4, 8'd0);
    wreg(5'd9, 8'd0);
    wreg(5'd5, 8'd0);
    wreg(5'd12, 8'h3F);
    wreg(5'd13, 8'hF0);
    repeat (64) ce_step();
    chk("ma_reload_top", int'(MA), 16'h3FF0);
    repeat (15) ce_step();
    chk("ma_top", int'(MA), 16'h3FFF);
    ce_step();
    chk("ma_wrap", int'(MA), 0);

    // with a zero start address MA tracks hcc directly
    wreg(5'd12, 8'h00);
    wreg(5'd13, 8'h00);
    cnt = 0;
    do begin ce_step(); cnt++; end while (MA != 0 && cnt < 100);
    chk("line_end_steps", cnt, 48);
    repeat (30) ce_step();
    chk("hcc_at_30", int'(MA), 30);
    wreg(5'd0, 8'd20);
    cnt = 0; mx = 0;
    do begin
      ce_step(); cnt++;
      if (int'(MA) > mx) mx = int'(MA);
    end while (MA != 0 && cnt < 400);
    chk("r0_shrink_wrap_steps", cnt, 226);
    chk("r0_shrink_max_hcc", mx, 255);
    cnt = 0;
    do begin ce_step(); cnt++; end while (MA != 0 && cnt < 400);
    chk("short_line_len", cnt, 21);

    // asynchronous reset while HSYNC is high
    wreg(5'd0, 8'd63);
    wreg(5'd3, 8'h8E);
    wreg(5'd9, 8'd7);
    steps_until_hs(1'b1, cnt);
    chk("hs_rise_line0", cnt, 46);
    steps_until_hs(1'b0, cnt);
    chk("hs_width_line0", cnt, 14);
    steps_until_hs(1'b1, cnt);
    chk("hs_rise_line1", cnt, 50);
    repeat (3) ce_step();
    chk("pre_rst_hs", int'(HSYNC), 1);
    chk("pre_rst_ma", int'(MA), 49);
    chk("pre_rst_ra", int'(RA), 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_hs", int'(HSYNC), 0);
    chk("async_rst_ma", int'(MA), 0);
    chk("async_rst_ra", int'(RA), 0);
    chk("async_rst_vs_de_q", int'({VSYNC, DE, Q}), 0);
    #1 RESET = 1'b0;
    tick();
    wr(1'b0, 8'd12);
    rd(qv);
    chk("post_rst_r12", int'(qv), 8'h30);
    steps_until_hs(1'b1, cnt);
    chk("post_rst_hs_rise", cnt, 46);
    steps_until_hs(1'b0, cnt);
    chk("post_rst_hs_width", cnt, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
